// File: rtl/puf_resp_reader_pkg.sv
// Shared types and constants for the PUF response reader: FSM state encoding,
// result widths and a constant-evaluable ceil(log2) helper.
package puf_resp_reader_pkg;

  localparam int RESP_W_DEF = 16;
  localparam int HD_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_EVAL,
    ST_DONE
  } state_e;

  // Never returns 0 so that derived counter widths stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/puf_resp_reader_if.sv
// PUF core link: level request with challenge out, one-cycle ack strobe with response back.
// No backpressure; the reader holds puf_req until ack or timeout.
interface puf_resp_reader_if #(
  parameter int RESP_W = 16
);
  logic [RESP_W-1:0] puf_chal;
  logic              puf_req;
  logic [RESP_W-1:0] puf_resp;
  logic              puf_ack;

  modport master (
    output puf_chal,
    output puf_req,
    input  puf_resp,
    input  puf_ack
  );

  modport slave (
    input  puf_chal,
    input  puf_req,
    output puf_resp,
    output puf_ack
  );
endinterface

// File: rtl/puf_resp_reader_popcount.sv
// Combinational population count of a W-bit vector; zero latency, no handshake.
module puf_popcount
  import puf_resp_reader_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]    vec_i,
  output logic [HD_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + HD_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/puf_resp_reader.sv
// PUF reader: NREP req/ack evaluations, per-bit majority vote, HD check against reference.
// Latency 2*NREP+1 edges after the start edge with immediate acks; PUF stalls bounded by TIMEOUT.
module puf_resp_reader
  import puf_resp_reader_pkg::*;
#(
  parameter int RESP_W  = RESP_W_DEF,
  parameter int NREP    = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RESP_W-1:0] chal,
  input  logic [RESP_W-1:0] ref_resp,
  input  logic [HD_W-1:0]   hd_thresh,
  puf_resp_reader_if.master puf,
  output logic [RESP_W-1:0] resp,
  output logic [HD_W-1:0]   hd,
  output logic              pass,
  output logic              timeout,
  output logic              done,
  output logic              busy
);

  localparam int VW = clog2(NREP + 1);
  localparam int TW = clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [RESP_W-1:0] chal_q, chal_d, ref_q, ref_d, resp_q, resp_d;
  logic [HD_W-1:0]   thr_q, thr_d, hd_q, hd_d;
  logic              pass_q, pass_d, tmo_q, tmo_d;
  logic [VW-1:0]     rep_q, rep_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [VW-1:0]     vote_q [RESP_W];
  logic [VW-1:0]     vote_d [RESP_W];
  logic [RESP_W-1:0] voted;
  logic [HD_W-1:0]   hd_eval;

  always_comb begin
    voted = '0;
    for (int i = 0; i < RESP_W; i++) begin
      voted[i] = (vote_q[i] > VW'(NREP / 2));
    end
  end

  puf_popcount #(.W(RESP_W)) u_popcount (
    .vec_i (voted ^ ref_q),
    .cnt_o (hd_eval)
  );

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    ref_d   = ref_q;
    thr_d   = thr_q;
    resp_d  = resp_q;
    hd_d    = hd_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    rep_d   = rep_q;
    timer_d = '0;
    vote_d  = vote_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d  = chal;
          ref_d   = ref_resp;
          thr_d   = hd_thresh;
          resp_d  = '0;
          hd_d    = '0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          rep_d   = '0;
          for (int i = 0; i < RESP_W; i++) vote_d[i] = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (puf.puf_ack) begin
          for (int i = 0; i < RESP_W; i++) begin
            vote_d[i] = vote_q[i] + VW'(puf.puf_resp[i]);
          end
          rep_d   = rep_q + VW'(1);
          state_d = ST_GAP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Abort: results are forced to a failing, all-zero verdict.
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          hd_d    = '0;
          resp_d  = '0;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GAP:  state_d = (rep_q < VW'(NREP)) ? ST_REQ : ST_EVAL;
      ST_EVAL: begin
        resp_d  = voted;
        hd_d    = hd_eval;
        pass_d  = (hd_eval <= thr_q);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chal_q  <= '0;
      ref_q   <= '0;
      thr_q   <= '0;
      resp_q  <= '0;
      hd_q    <= '0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rep_q   <= '0;
      timer_q <= '0;
      for (int i = 0; i < RESP_W; i++) vote_q[i] <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      ref_q   <= ref_d;
      thr_q   <= thr_d;
      resp_q  <= resp_d;
      hd_q    <= hd_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      rep_q   <= rep_d;
      timer_q <= timer_d;
      vote_q  <= vote_d;
    end
  end

  assign puf.puf_chal = chal_q;
  assign puf.puf_req  = (state_q == ST_REQ);
  assign resp         = resp_q;
  assign hd           = hd_q;
  assign pass         = pass_q;
  assign timeout      = tmo_q;
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_puf_resp_reader.sv
// Bench for puf_resp_reader: behavioural PUF responder plus a bit-count majority reference.
module tb_puf_resp_reader;
  import puf_resp_reader_pkg::*;

  localparam int RW = 16;
  localparam int NR = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] chal = '0;
  logic [RW-1:0] ref_resp = '0;
  logic [4:0]    hd_thresh = '0;
  logic [RW-1:0] resp;
  logic [4:0]    hd;
  logic          pass, timeout, done, busy;

  puf_resp_reader_if #(.RESP_W(RW)) pif ();

  puf_resp_reader #(.RESP_W(RW), .NREP(NR), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .chal      (chal),
    .ref_resp  (ref_resp),
    .hd_thresh (hd_thresh),
    .puf       (pif.master),
    .resp      (resp),
    .hd        (hd),
    .pass      (pass),
    .timeout   (timeout),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PUF responder: answers cycle through answers[], optionally after a random stall.
  logic [RW-1:0] answers [NR];
  bit            no_ack = 1'b0;
  bit            spur_en = 1'b0;
  int            max_delay = 0;
  int            ans_idx = 0;
  int            wait_cnt = 0;

  always @(negedge clk) begin
    if (pif.puf_req === 1'b1 && pif.puf_ack !== 1'b1 && !no_ack) begin
      if (wait_cnt > 0) begin
        wait_cnt = wait_cnt - 1;
        pif.puf_ack = 1'b0;
      end else begin
        pif.puf_resp = answers[ans_idx % NR];
        pif.puf_ack  = 1'b1;
        ans_idx      = ans_idx + 1;
        wait_cnt     = $urandom_range(0, max_delay);
      end
    end else if (pif.puf_req === 1'b0 && spur_en) begin
      pif.puf_ack  = 1'($urandom_range(0, 1));
      pif.puf_resp = 16'($urandom);
    end else begin
      pif.puf_ack = 1'b0;
    end
  end

  // Any NR consecutive answers cover the whole table, so vote order never matters.
  task automatic model(input logic [RW-1:0] r, input logic [4:0] t,
                       output logic [RW-1:0] e_resp, output logic [4:0] e_hd, output logic e_pass);
    e_resp = '0;
    for (int b = 0; b < RW; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < NR; k++) ones += int'(answers[k][b]);
      e_resp[b] = (2 * ones > NR);
    end
    e_hd   = 5'($countones(e_resp ^ r));
    e_pass = (e_hd <= t);
  endtask

  // Returns in the done cycle; edges counts rising edges with the start-sampling edge as 1.
  task automatic run_eval(input logic [RW-1:0] c, input logic [RW-1:0] r, input logic [4:0] t,
                          input bit hold, output int edges);
    @(negedge clk);
    chal = c;
    ref_resp = r;
    hd_thresh = t;
    start = 1'b1;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        chk("busy_after_start", busy, 1);
        if (!hold) start = 1'b0;
        else begin
          chal = ~c;
          ref_resp = ~r;
          hd_thresh = ~t;
        end
      end
      if (edges == 3) chk("chal_stable", pif.puf_chal, c);
      if (done === 1'b1) break;
    end
    chk("done_seen", done, 1);
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [RW-1:0] r, input logic [4:0] t,
                               input bit exp_tmo);
    logic [RW-1:0] e_resp;
    logic [4:0]    e_hd;
    logic          e_pass;
    if (exp_tmo) begin
      e_resp = '0;
      e_hd   = '0;
      e_pass = 1'b0;
    end else begin
      model(r, t, e_resp, e_hd, e_pass);
    end
    chk({tag, "_resp"}, resp, e_resp);
    chk({tag, "_hd"}, hd, e_hd);
    chk({tag, "_pass"}, pass, e_pass);
    chk({tag, "_timeout"}, timeout, exp_tmo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int e;
    logic [RW-1:0] base, r;
    logic [4:0] t;
    bit hold;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", pif.puf_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_hd", hd, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_chal", pif.puf_chal, 0);
    rst_n = 1'b1;

    // Stable PUF, immediate acks.
    for (int k = 0; k < NR; k++) answers[k] = 16'hA5C3;
    run_eval(16'h1234, 16'hA5C3, 5'd0, 1'b0, e);
    chk("stable_latency", e, 2 * NR + 2);
    chk("stable_resp", resp, 16'hA5C3);
    chk("stable_pass", pass, 1);
    check_results("stable", 16'hA5C3, 5'd0, 1'b0);

    // Noisy bit0: two flips out of five, then three.
    answers[0] = 16'h00FE; answers[1] = 16'h00FE;
    answers[2] = 16'h00FF; answers[3] = 16'h00FF; answers[4] = 16'h00FF;
    run_eval(16'h0001, 16'h00FF, 5'd0, 1'b0, e);
    chk("noisy2_resp", resp, 16'h00FF);
    check_results("noisy2", 16'h00FF, 5'd0, 1'b0);
    answers[2] = 16'h00FE;
    run_eval(16'h0002, 16'h00FF, 5'd0, 1'b0, e);
    chk("noisy3_resp", resp, 16'h00FE);
    chk("noisy3_hd", hd, 1);
    chk("noisy3_pass_t0", pass, 0);
    check_results("noisy3_t0", 16'h00FF, 5'd0, 1'b0);
    run_eval(16'h0002, 16'h00FF, 5'd1, 1'b0, e);
    chk("noisy3_pass_t1", pass, 1);
    check_results("noisy3_t1", 16'h00FF, 5'd1, 1'b0);

    // Reset held two cycles while the PUF is being requested.
    no_ack = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_req_before", pif.puf_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req", pif.puf_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_resp", resp, 0);
    chk("midrst_hd", hd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;

    // HD boundary.
    for (int k = 0; k < NR; k++) answers[k] = 16'h000F;
    run_eval(16'h0F0F, 16'h0000, 5'd4, 1'b0, e);
    chk("hd4_hd", hd, 4);
    chk("hd4_pass", pass, 1);
    check_results("hd4", 16'h0000, 5'd4, 1'b0);
    run_eval(16'h0F0F, 16'h0000, 5'd3, 1'b0, e);
    chk("hd3_pass", pass, 0);
    check_results("hd3", 16'h0000, 5'd3, 1'b0);

    // Silent PUF.
    no_ack = 1'b1;
    run_eval(16'hBEEF, 16'h0000, 5'd16, 1'b0, e);
    chk("tmo_latency", e, TO + 1);
    chk("tmo_req_low", pif.puf_req, 0);
    check_results("tmo", 16'h0000, 5'd16, 1'b1);
    no_ack = 1'b0;

    // Start held through the evaluation, inputs changing, stray acks outside REQ.
    spur_en = 1'b1;
    answers[0] = 16'h1111; answers[1] = 16'h3333; answers[2] = 16'h7777;
    answers[3] = 16'hF0F0; answers[4] = 16'h0F0F;
    run_eval(16'hCAFE, 16'h3377, 5'd2, 1'b1, e);
    check_results("proto", 16'h3377, 5'd2, 1'b0);
    run_eval(16'hD00D, 16'h0000, 5'd9, 1'b0, e);
    check_results("b2b", 16'h0000, 5'd9, 1'b0);
    spur_en = 1'b0;

    // Randomized evaluations with stalls.
    max_delay = 3;
    for (int n = 0; n < 20; n++) begin
      base = 16'($urandom);
      for (int k = 0; k < NR; k++) answers[k] = base ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      r = base ^ (16'($urandom) & 16'($urandom));
      t = 5'($urandom_range(0, 8));
      spur_en = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      run_eval(16'($urandom), r, t, hold, e);
      check_results("rand", r, t, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
